// File: rtl/alu_operand_pkg.sv
// ALU operand stage shared types.
// Operand select encodings and the x0 index.
package alu_operand_pkg;

  typedef enum logic [1:0] {
    A_RS1  = 2'd0,
    A_PC   = 2'd1,
    A_ZERO = 2'd2
  } a_sel_t;

  typedef enum logic [1:0] {
    B_RS2  = 2'd0,
    B_IMM  = 2'd1,
    B_FOUR = 2'd2
  } b_sel_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/operand_forward_unit.sv
// Combinational forwarding resolve for one source register.
// Ports: addr/used/rf_data, fwd_* entries -> data, stall.
module operand_forward_unit
  import alu_operand_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 2
) (
  input  logic [4:0]                    addr,
  input  logic                          used,
  input  logic [XLEN-1:0]               rf_data,
  input  logic [NUM_FWD-1:0]            fwd_valid,
  input  logic [NUM_FWD-1:0]            fwd_busy,
  input  logic [NUM_FWD-1:0][4:0]       fwd_rd,
  input  logic [NUM_FWD-1:0][XLEN-1:0]  fwd_data,
  output logic [XLEN-1:0]               data,
  output logic                          stall
);

  logic hit;

  // Entry 0 is youngest; first match wins and
  // shadows any older entry, busy or not.
  always_comb begin
    data  = rf_data;
    stall = 1'b0;
    hit   = 1'b0;
    for (int i = 0; i < NUM_FWD; i++) begin
      if (!hit && fwd_valid[i] &&
          fwd_rd[i] == addr &&
          addr != REG_ZERO) begin
        hit   = 1'b1;
        data  = fwd_data[i];
        stall = used && fwd_busy[i];
      end
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// Registered ALU operand select with forwarding and load-use stall.
// Ports: decode side in_*, fwd_* bypass, EX side out_*/a/b/store_data.
module alu_operand_stage
  import alu_operand_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 2,
  parameter int CNT_W   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [4:0]                    rs1_addr,
  input  logic [4:0]                    rs2_addr,
  input  logic                          rs1_used,
  input  logic                          rs2_used,
  input  logic [XLEN-1:0]               rs1_data,
  input  logic [XLEN-1:0]               rs2_data,
  input  logic [XLEN-1:0]               pc,
  input  logic [XLEN-1:0]               imm,
  input  a_sel_t                        a_sel,
  input  b_sel_t                        b_sel,
  input  logic [NUM_FWD-1:0]            fwd_valid,
  input  logic [NUM_FWD-1:0]            fwd_busy,
  input  logic [NUM_FWD-1:0][4:0]       fwd_rd,
  input  logic [NUM_FWD-1:0][XLEN-1:0]  fwd_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [XLEN-1:0]               a,
  output logic [XLEN-1:0]               b,
  output logic [XLEN-1:0]               store_data,
  output logic [CNT_W-1:0]              stall_cnt
);

  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;
  logic            rs1_stall;
  logic            rs2_stall;
  logic            hazard;
  logic            accept;
  logic [XLEN-1:0] a_nxt;
  logic [XLEN-1:0] b_nxt;

  operand_forward_unit #(
    .XLEN    (XLEN),
    .NUM_FWD (NUM_FWD)
  ) u_fwd_rs1 (
    .addr      (rs1_addr),
    .used      (rs1_used),
    .rf_data   (rs1_data),
    .fwd_valid (fwd_valid),
    .fwd_busy  (fwd_busy),
    .fwd_rd    (fwd_rd),
    .fwd_data  (fwd_data),
    .data      (rs1_fwd),
    .stall     (rs1_stall)
  );

  operand_forward_unit #(
    .XLEN    (XLEN),
    .NUM_FWD (NUM_FWD)
  ) u_fwd_rs2 (
    .addr      (rs2_addr),
    .used      (rs2_used),
    .rf_data   (rs2_data),
    .fwd_valid (fwd_valid),
    .fwd_busy  (fwd_busy),
    .fwd_rd    (fwd_rd),
    .fwd_data  (fwd_data),
    .data      (rs2_fwd),
    .stall     (rs2_stall)
  );

  assign hazard   = in_valid && (rs1_stall || rs2_stall);
  assign in_ready = !flush && !hazard &&
                    (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    case (a_sel)
      A_RS1:   a_nxt = rs1_fwd;
      A_PC:    a_nxt = pc;
      default: a_nxt = '0;
    endcase
  end

  always_comb begin
    case (b_sel)
      B_RS2:   b_nxt = rs2_fwd;
      B_IMM:   b_nxt = imm;
      B_FOUR:  b_nxt = XLEN'(4);
      default: b_nxt = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      a          <= '0;
      b          <= '0;
      store_data <= '0;
      stall_cnt  <= '0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid  <= 1'b1;
        a          <= a_nxt;
        b          <= b_nxt;
        store_data <= rs2_fwd;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (hazard && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule
